demux_1ton_stream: RTL and testbench
====================================

# demux_1toN_stream

Packet-aware, parametrised 1:N stream demultiplexer, successor to the combinational 1:N demux. It accepts a valid/ready input stream with a per-packet channel select and routes every beat of a packet to one of N output channels through a single registered output stage. The select is locked for the whole packet; packets with an out-of-range select are dropped and counted. It sits between a shared ingress stream and N per-channel consumers.

## Interface
- `N`, default 8: number of output channels, ≥2, need not be a power of two.
- `W`, default 8: data width in bits.
- `SW`, localparam: select width, `$clog2(N)`.
- `CW`, default 16: drop-counter width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`.
- `s_data`  in  W  input beat data.
- `s_last`  in  1  final beat of packet.
- `s_sel`  in  SW  destination channel; sampled on the first beat of a packet only.
- `m_valid`  out  N  one-hot (or zero) output valid, bit i = channel i.
- `m_ready`  in  N  per-channel ready.
- `m_data`  out  W  shared output data, meaningful for the channel whose `m_valid` bit is set.
- `m_last`  out  1  shared last flag.
- `busy`  out  1  high while a packet is mid-flight (state ≠ IDLE).
- `drop_cnt`  out  CW  saturating count of dropped packets.

## Operation
- FSM states: IDLE (between packets), FWD (packet locked to `lock_ch`), DROP (discarding an illegal packet).
- IDLE, accepted beat with `s_sel < N`: `lock_ch <= s_sel`; beat loaded into the output register; next state is FWD unless `s_last`, in which case stay IDLE.
- IDLE, beat with `s_sel ≥ N`: `s_ready` is 1 unconditionally. Beat discarded; `drop_cnt` increments (saturates at all-ones); next state is DROP unless `s_last`.
- FWD: `s_sel` is ignored. Beats go to `lock_ch`. An accepted beat with `s_last` returns the FSM to IDLE.
- DROP: `s_ready` is 1. Beats are discarded. An accepted beat with `s_last` returns the FSM to IDLE. `drop_cnt` does not increment again.
- Output register holds `out_valid`, `out_ch`, `m_data`, and `m_last`.
- `m_valid = out_valid ? (1 << out_ch) : 0`.
- Forwarding `s_ready = !out_valid || m_ready[out_ch]`. This gives full throughput with no bubble when the consumer is ready.
- The output register drains when `m_ready[out_ch]` is high. It is reloaded in the same cycle if a new beat is accepted, including when that beat targets a different channel.
- `m_ready` bits of non-selected channels have no effect.
- Reset values: `s_ready`=1, `m_valid`=0, `m_data`=0, `m_last`=0, `out_ch`=0, `lock_ch`=0, `busy`=0, `drop_cnt`=0, state IDLE. Reset is asynchronous and takes effect immediately, including mid-packet.

## Timing
- Latency from an accepted input beat to `m_valid`: 1 cycle.
- `s_ready` is combinational from `m_ready[out_ch]` and the state registers. `s_valid` does not feed `s_ready`.
- Output stability: while `m_valid[i]=1` and `m_ready[i]=0`, `m_data`, `m_last`, and `m_valid` hold unchanged.
- Single-beat packet (`s_last` on the first beat) never leaves IDLE.
- Back-to-back packets to different channels require no idle cycle.
- `drop_cnt` updates on the clock edge that accepts the first beat of an illegal packet.

## Structure
- Shared package `demux_pkg`:
  - state enum `demux_state_e` {IDLE, FWD, DROP};
  - `DEMUX_CW_DEFAULT`.
- One sub-module: `demux_out_slice`, the W+SW+1-bit output register with load/drain handshake, parametrised on W and SW. The FSM and drop logic stay in the top module.

## Test plan
- N=8, W=8: packet sel=3, 4 beats (0x11..0x14), all `m_ready`=1. Expected: `m_valid`=0x08 for 4 consecutive cycles starting 1 cycle after the first accept. `m_last` is set on 0x14 only. `busy` is high during beats 2–4.
- Mid-packet `s_sel` change: packet sel=1 of 3 beats, with `s_sel` driven to 5 on beats 2–3. Expected: all 3 beats appear only on `m_valid`=0x02.
- Backpressure: `m_ready[2]`=0 for 3 cycles during a packet to ch2. Expected:
  - `s_ready`=0 and `m_data` held constant;
  - after release, one beat per cycle and no data lost.
- Channel switch: single-beat packets to ch0, ch7, ch0 back-to-back with `m_ready`=all-ones. Expected: `m_valid` = 0x01, 0x80, 0x01 on consecutive cycles.
- N=6: packet sel=6, 3 beats. Expected:
  - `s_ready`=1 throughout and `m_valid` stays 0;
  - `drop_cnt` 0→1;
  - the next packet sel=5 delivers on `m_valid`=0x20.
- Reset: assert `rst_n`=0 mid-packet (FWD, output holding a beat). Expected:
  - immediately `m_valid`=0, `busy`=0, `drop_cnt`=0;
  - after release, the first beat with sel=4 routes to ch4.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and defaults for the packet-aware 1:N stream demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } demux_state_e;

  localparam int DEMUX_N_DEFAULT  = 8;
  localparam int DEMUX_W_DEFAULT  = 8;
  localparam int DEMUX_CW_DEFAULT = 16;

endpackage

// File: rtl/demux_1ton_stream_if.sv
// Ingress stream plus the N-way egress bundle of the demultiplexer.
// master = stream producer / channel consumers, slave = the demux itself.
interface demux_1ton_stream_if
  import demux_pkg::*;
#(
  parameter int N  = DEMUX_N_DEFAULT,
  parameter int W  = DEMUX_W_DEFAULT,
  parameter int SW = $clog2(N)
);

  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_last;
  logic [SW-1:0] s_sel;

  logic [N-1:0]  m_valid;
  logic [N-1:0]  m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;

  modport master (
    output s_valid, s_data, s_last, s_sel, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, s_sel, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/demux_out_slice.sv
// Single registered output stage: holds one beat (data, channel, last) and
// its valid flag. A load in the same cycle as a drain simply overwrites.
module demux_out_slice #(
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_ch,
  input  logic          in_last,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_ch,
  output logic          out_last
);

  // Capture a new beat on load, otherwise free the slot once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_ch    <= in_ch;
      out_last  <= in_last;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1ton_stream.sv
// Packet-aware 1:N stream demultiplexer. The channel select is latched on the
// first beat of each packet; packets with an out-of-range select are swallowed
// and counted.
//
//   state | meaning
//   IDLE  | between packets, next accepted beat is a packet head
//   FWD   | mid-packet, beats routed to lock_ch_q
//   DROP  | mid-packet of an illegal packet, beats discarded
module demux_1ton_stream
  import demux_pkg::*;
#(
  parameter int N  = DEMUX_N_DEFAULT,
  parameter int W  = DEMUX_W_DEFAULT,
  parameter int CW = DEMUX_CW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_1ton_stream_if.slave  bus,
  output logic                busy,
  output logic [CW-1:0]       drop_cnt
);

  localparam int SW = $clog2(N);

  demux_state_e  state_q, state_d;
  logic [SW-1:0] lock_ch_q;
  logic [SW-1:0] load_ch;
  logic [SW-1:0] out_ch;
  logic [N-1:0]  ch_onehot;
  logic          out_valid;
  logic          sel_ok;
  logic          drain;
  logic          fwd_ready;
  logic          accept;
  logic          load;

  assign sel_ok      = 32'(bus.s_sel) < 32'(N);
  assign ch_onehot   = {{(N-1){1'b0}}, 1'b1} << out_ch;
  assign bus.m_valid = out_valid ? ch_onehot : '0;
  // Only the ready bit of the channel currently holding a beat can drain it.
  assign drain       = |(bus.m_valid & bus.m_ready);
  assign fwd_ready   = !out_valid || drain;
  assign accept      = bus.s_valid && bus.s_ready;
  assign busy        = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: packet heads leave IDLE unless single-beat; last beats return.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && !bus.s_last) state_d = sel_ok ? FWD : DROP;
      FWD, DROP: if (accept && bus.s_last) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs: ingress ready and output-stage load per state.
  always_comb begin
    bus.s_ready = 1'b1;
    load        = 1'b0;
    load_ch     = lock_ch_q;
    case (state_q)
      IDLE: begin
        bus.s_ready = sel_ok ? fwd_ready : 1'b1;
        load        = bus.s_valid && sel_ok && fwd_ready;
        load_ch     = bus.s_sel;
      end
      FWD: begin
        bus.s_ready = fwd_ready;
        load        = bus.s_valid && fwd_ready;
      end
      default: ;
    endcase
  end

  // Lock the destination channel on a legal packet head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               lock_ch_q <= '0;
    else if (state_q == IDLE && accept && sel_ok) lock_ch_q <= bus.s_sel;
  end

  // Count illegal packet heads, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (state_q == IDLE && accept && !sel_ok && drop_cnt != '1)
      drop_cnt <= drop_cnt + CW'(1);
  end

  demux_out_slice #(
    .W  (W),
    .SW (SW)
  ) u_out_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .drain     (drain),
    .in_data   (bus.s_data),
    .in_ch     (load_ch),
    .in_last   (bus.s_last),
    .out_valid (out_valid),
    .out_data  (bus.m_data),
    .out_ch    (out_ch),
    .out_last  (bus.m_last)
  );

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Bench for demux_1ton_stream: one N=8 and one N=6 instance, checked every
// cycle against a packet-level reference model (expected-beat queues).
module tb_demux_1ton_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_1ton_stream_if #(.N(8), .W(8)) ifa ();
  demux_1ton_stream_if #(.N(6), .W(8)) ifb ();

  logic        busy_a, busy_b;
  logic [15:0] dc_a, dc_b;

  demux_1ton_stream #(.N(8), .W(8), .CW(16)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa), .busy (busy_a), .drop_cnt (dc_a));
  demux_1ton_stream #(.N(6), .W(8), .CW(16)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb), .busy (busy_b), .drop_cnt (dc_b));

  // Instance-neutral views, index 0 = N8, index 1 = N6.
  logic       sv[2];
  logic [7:0] sd[2];
  logic       sl[2];
  logic [2:0] ss[2];
  logic [7:0] mr[2];

  logic        sr_o[2];
  logic [7:0]  mv_o[2];
  logic [7:0]  md_o[2];
  logic        ml_o[2];
  logic        busy_o[2];
  logic [15:0] dc_o[2];

  assign ifa.s_valid = sv[0]; assign ifa.s_data = sd[0]; assign ifa.s_last = sl[0];
  assign ifa.s_sel   = ss[0]; assign ifa.m_ready = mr[0];
  assign ifb.s_valid = sv[1]; assign ifb.s_data = sd[1]; assign ifb.s_last = sl[1];
  assign ifb.s_sel   = ss[1]; assign ifb.m_ready = mr[1][5:0];

  assign sr_o[0] = ifa.s_ready; assign mv_o[0] = ifa.m_valid;
  assign md_o[0] = ifa.m_data;  assign ml_o[0] = ifa.m_last;
  assign busy_o[0] = busy_a;    assign dc_o[0] = dc_a;
  assign sr_o[1] = ifb.s_ready; assign mv_o[1] = {2'b00, ifb.m_valid};
  assign md_o[1] = ifb.m_data;  assign ml_o[1] = ifb.m_last;
  assign busy_o[1] = busy_b;    assign dc_o[1] = dc_b;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  // Reference model state: packet position, drop mode, counter, pending beats.
  beat_t q[2][$];
  int    nsz[2] = '{8, 6};
  bit    in_pkt[2];
  bit    drop_mode[2];
  int    pkt_ch[2];
  int    cnt[2];
  bit    acc[2];
  bit    rand_mode = 0;
  int    bp_left = 0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      in_pkt[k] = 0; drop_mode[k] = 0; pkt_ch[k] = 0; cnt[k] = 0; acc[k] = 0;
    end
  endtask

  // Compare DUT k against the model for the upcoming edge, then advance the model.
  task automatic observe(int k);
    logic exp_sr;
    if (drop_mode[k] || (!in_pkt[k] && int'(ss[k]) >= nsz[k])) exp_sr = 1'b1;
    else if (q[k].size() == 0)                                  exp_sr = 1'b1;
    else                                                        exp_sr = mr[k][q[k][0].ch];
    chk($sformatf("s_ready%0d", k), 32'(sr_o[k]), 32'(exp_sr));
    chk($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(in_pkt[k]));
    chk($sformatf("drop_cnt%0d", k), 32'(dc_o[k]), 32'(cnt[k]));
    if (q[k].size() == 0) begin
      chk($sformatf("m_valid_idle%0d", k), 32'(mv_o[k]), 32'h0);
    end else begin
      chk($sformatf("m_valid%0d", k), 32'(mv_o[k]), 32'(8'd1 << q[k][0].ch));
      chk($sformatf("m_data%0d", k), 32'(md_o[k]), 32'(q[k][0].data));
      chk($sformatf("m_last%0d", k), 32'(ml_o[k]), 32'(q[k][0].last));
    end
    acc[k] = sv[k] && sr_o[k];
    if (q[k].size() != 0 && mr[k][q[k][0].ch]) void'(q[k].pop_front());
    if (acc[k]) begin
      if (!in_pkt[k]) begin
        pkt_ch[k]    = int'(ss[k]);
        drop_mode[k] = (pkt_ch[k] >= nsz[k]);
        if (drop_mode[k] && cnt[k] < 65535) cnt[k]++;
      end
      if (!drop_mode[k]) q[k].push_back('{ch: pkt_ch[k], data: sd[k], last: sl[k]});
      in_pkt[k] = !sl[k];
      if (sl[k]) drop_mode[k] = 0;
    end
  endtask

  task automatic cycle();
    for (int k = 0; k < 2; k++) mr[k] = rand_mode ? 8'($urandom) : 8'hFF;
    if (bp_left > 0) begin
      mr[0][2] = 1'b0;
      bp_left--;
    end
    @(negedge clk);
    observe(0);
    observe(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_pkt(int k, int sel, int nb, logic [7:0] base, int sel_later, int bp_beat);
    int t;
    for (int b = 0; b < nb; b++) begin
      sv[k] = 1'b1;
      sd[k] = base + 8'(b);
      sl[k] = (b == nb - 1);
      ss[k] = (b == 0) ? 3'(sel) : 3'(sel_later);
      if (b == bp_beat) bp_left = 3;
      t = 0;
      do begin
        cycle();
        t++;
      end while (!acc[k] && t < 50);
      if (!acc[k]) chk($sformatf("accept_timeout%0d", k), 32'(acc[k]), 32'h1);
    end
    sv[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      sv[k] = 0; sd[k] = 0; sl[k] = 0; ss[k] = 0; mr[k] = 8'hFF;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_s_ready%0d", k), 32'(sr_o[k]), 32'h1);
      chk($sformatf("rst_m_valid%0d", k), 32'(mv_o[k]), 32'h0);
      chk($sformatf("rst_m_data%0d", k), 32'(md_o[k]), 32'h0);
      chk($sformatf("rst_m_last%0d", k), 32'(ml_o[k]), 32'h0);
      chk($sformatf("rst_busy%0d", k), 32'(busy_o[k]), 32'h0);
      chk($sformatf("rst_drop_cnt%0d", k), 32'(dc_o[k]), 32'h0);
    end
    rst_n = 1'b1;
    idle(2);

    // Four-beat packet to ch3, consumer always ready.
    send_pkt(0, 3, 4, 8'h11, 3, -1);
    idle(2);
    // Select changes mid-packet must be ignored.
    send_pkt(0, 1, 3, 8'h21, 5, -1);
    idle(2);
    // Backpressure on ch2 for three cycles after the first beat.
    send_pkt(0, 2, 5, 8'h31, 2, 1);
    idle(2);
    // Back-to-back single-beat packets switching channel.
    send_pkt(0, 0, 1, 8'hA0, 0, -1);
    send_pkt(0, 7, 1, 8'hA1, 0, -1);
    send_pkt(0, 0, 1, 8'hA2, 0, -1);
    idle(2);
    // Illegal select on the N=6 instance, then a legal packet to ch5.
    send_pkt(1, 6, 3, 8'h41, 6, -1);
    chk("drop_cnt_after_drop", 32'(dc_o[1]), 32'h1);
    send_pkt(1, 5, 2, 8'h51, 0, -1);
    idle(2);

    // Asynchronous reset while a packet is mid-flight with a beat held.
    sv[0] = 1'b1; sd[0] = 8'h55; sl[0] = 1'b0; ss[0] = 3'd1;
    cycle();
    sd[0] = 8'h56;
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 32'(mv_o[0]), 32'h0);
    chk("midrst_busy", 32'(busy_o[0]), 32'h0);
    chk("midrst_drop_cnt", 32'(dc_o[1]), 32'h0);
    chk("midrst_s_ready", 32'(sr_o[0]), 32'h1);
    sv[0] = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(0, 4, 2, 8'h61, 0, -1);
    idle(2);

    // Randomised packets with random per-channel ready on both instances.
    rand_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send_pkt(i % 2, int'($urandom_range(0, 7)), int'($urandom_range(1, 4)),
               8'($urandom), int'($urandom_range(0, 7)), -1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_mode = 0;
    idle(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
